mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial memory controller between the core and the single-port, 8-bit-wide RAM/IO bus. Serves two requesters: the LSB (committed loads/stores of 1, 2 or 4 bytes) and the instruction fetch unit (4-byte fetches). It is the responder end of the LSB `lsb_read_signal`/`lsb_write_signal` protocol. It serialises each access into byte transfers, assembles and sign/zero-extends load data, and aborts speculative reads on `jump_wrong`.

## Interface
- `IO_BASE`, default 32'h0003_0000: addresses >= this are IO and are subject to `io_buffer_full` back-pressure on writes.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `rdy` input 1: global enable; low means freeze.
- `jump_wrong` input 1: misprediction flush.
- `lsb_read_signal` input 1: LSB load request, level, held until `mem_load_success`.
- `lsb_write_signal` input 1: LSB store request, level, held until `mem_store_success`.
- `requiring_length` input 3: byte count; only 1, 2 or 4 are legal.
- `to_mem_addr` input 32: LSB byte address.
- `to_mem_data` input 32: store data; low bytes are used.
- `load_signed` input 1: 1 means sign-extend a 1/2-byte load.
- `mem_load_success` output 1: one-cycle pulse; `from_mem_data` is valid in the same cycle.
- `from_mem_data` output 32: extended load result.
- `mem_store_success` output 1: one-cycle pulse at store completion.
- `if_request` input 1: fetch request, level, held until `if_success`.
- `if_addr` input 32: fetch address.
- `if_success` output 1: one-cycle pulse; `if_instr` is valid.
- `if_instr` output 32: fetched word, little-endian.
- `mem_din` input 8: RAM read data, for the address driven in the previous cycle.
- `mem_dout` output 8: RAM write data.
- `mem_a` output 32: RAM byte address.
- `mem_wr` output 1: 1 = write, 0 = read.
- `io_buffer_full` input 1: IO write buffer full.

## Operation
- States:
  - IDLE
  - FETCH (4-byte read for ifetch)
  - LOAD (N-byte read for LSB)
  - STORE (N-byte write for LSB)
- A byte counter tracks bytes issued (0..N), and a separate counter tracks bytes received for reads.
- Request acceptance, in IDLE only:
  - Requests are not accepted in a cycle where any success pulse is high; the requester drops its level at the edge ending that cycle.
  - Priority: `lsb_write_signal` > `lsb_read_signal` > `if_request`. Committed LSB traffic is older than fetch.
- On acceptance the controller latches the address, length, data and `load_signed`.
- Byte order is little-endian: byte k goes to address `addr+k` and data bits [8k+7:8k]. Address arithmetic is 32-bit and wraps modulo 2^32.
- LOAD extension:
  - N=1: `load_signed` ? sign-extend bit 7 : zero-extend.
  - N=2: same rule from bit 15.
  - N=4: unchanged.
- FETCH: 4 bytes are assembled into `if_instr`; no extension.
- STORE to an IO address while `io_buffer_full`=1:
  - The current byte is not issued: `mem_wr`=0 and the counter holds.
  - It is issued in the first cycle `io_buffer_full`=0.
- `jump_wrong`=1 with `rdy`=1:
  - In FETCH or LOAD: abort at that edge, go to IDLE, drive `mem_wr`=0, and emit no success pulse. Partial data is discarded.
  - In STORE: ignored. Committed stores always complete and still pulse `mem_store_success`.
  - In IDLE: no request is accepted that cycle.
- `rdy`=0:
  - No state, counter or output register changes.
  - `mem_wr` is forced to 0 combinationally, so a write byte is never repeated; it is re-driven once `rdy` returns.
  - `mem_a` is held, so read data remains consistent across the freeze.
- `rst`: takes priority over everything.
  - State goes to IDLE and the counters to 0.
  - `mem_a`, `mem_dout`, `mem_wr`, `from_mem_data`, `if_instr`, and all success pulses go to 0.

## Timing
- Cycle 0 is the cycle in which IDLE samples an accepted request. Cycle 1 begins at the following edge.
- Read of N bytes (LOAD N∈{1,2,4}, FETCH N=4):
  - `mem_a`=`addr+k` with `mem_wr`=0 during cycle k+1, for k=0..N-1.
  - The byte k value on `mem_din` is sampled at the end of cycle k+2.
  - The success pulse and data are high during cycle N+2; the state is IDLE in that cycle.
  - Total latency: N+2 cycles from acceptance to pulse. A 4-byte fetch pulses in cycle 6.
- Write of N bytes, no stall:
  - `mem_a`=`addr+k`, `mem_dout`=byte k, `mem_wr`=1 during cycle k+1.
  - `mem_store_success` is high during cycle N+1.
  - Each IO stall cycle adds one cycle.
- Between operations: a new request can be accepted at the earliest in the cycle after a success pulse. Back-to-back 1-byte loads therefore complete every 4 cycles.
- Outside write cycles: `mem_wr`=0 and `mem_dout`=0 in all IDLE and read cycles.
- Success pulses never overlap, and are never high in the same cycle as `rst`.

## Test plan
- **Word load:**
  - Stimulus: RAM[0x100..0x103]=78 56 34 12; LSB read, length 4, address 0x100, accepted in cycle 0.
  - Response: `mem_a` = 0x100..0x103 in cycles 1–4; `mem_load_success` in cycle 6 with `from_mem_data`=0x12345678.
- **Sign and zero extension:**
  - Stimulus: RAM[0x200]=0x80, RAM[0x201]=0xFF.
  - Signed byte load → 0xFFFFFF80. Unsigned byte load → 0x00000080. Signed half load → 0xFFFFFF80. Unsigned half load → 0x0000FF80.
- **Half store with IO stall:**
  - Stimulus: store length 2, address 0x30004, data 0xAABBCCDD; `io_buffer_full`=1 for cycles 1–2.
  - Response: `mem_wr`=0 in cycles 1–2; byte 0xDD to 0x30004 in cycle 3; byte 0xCC to 0x30005 in cycle 4; `mem_store_success` in cycle 5.
- **Arbitration:**
  - Stimulus: `if_request` and `lsb_read_signal` both asserted in the same IDLE cycle.
  - Response: the LSB load is served first; the fetch is accepted in the cycle after `mem_load_success`.
- **Flush:**
  - Stimulus 1: `jump_wrong` in cycle 3 of a fetch. Response: IDLE next cycle, no `if_success`.
  - Stimulus 2: `jump_wrong` during cycle 2 of a 4-byte store. Response: all 4 bytes are still written and `mem_store_success` is high in cycle 5.
- **Freeze and reset:**
  - Stimulus: `rdy`=0 for 3 cycles mid-load. Response: identical result, with latency extended by 3 cycles.
  - Stimulus: `rst` in cycle 2 of a store. Response: all outputs read 0 next cycle; no success pulse.

Source files
------------

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM/IO controller for LSB loads/stores and instruction fetch
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong,
  input  logic        lsb_read_signal,
  input  logic        lsb_write_signal,
  input  logic [2:0]  requiring_length,
  input  logic [31:0] to_mem_addr,
  input  logic [31:0] to_mem_data,
  input  logic        load_signed,
  output logic        mem_load_success,
  output logic [31:0] from_mem_data,
  output logic        mem_store_success,
  input  logic        if_request,
  input  logic [31:0] if_addr,
  output logic        if_success,
  output logic [31:0] if_instr,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  len_q, len_d;
  logic        sgn_q, sgn_d;
  logic [2:0]  iss_q, iss_d;
  logic [2:0]  rcv_q, rcv_d;
  logic        avld_q, avld_d;
  logic        rpend_q, rpend_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  dout_q, dout_d;
  logic        wr_q, wr_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic [31:0] instr_q, instr_d;
  logic        ld_ok_q, ld_ok_d;
  logic        st_ok_q, st_ok_d;
  logic        if_ok_q, if_ok_d;

  logic        frz_q;
  logic [7:0]  din_hold_q;
  logic [7:0]  byte_in;
  logic [31:0] assembled;
  logic [2:0]  iss_nx;
  logic        io_stall;
  logic        pulse_busy;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] n,
                                         input logic s);
    logic [31:0] r;
    case (n)
      3'd1:    r = {{24{s & w[7]}}, w[7:0]};
      3'd2:    r = {{16{s & w[15]}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // The RAM keeps clocking during a freeze, so the byte that was on mem_din
  // when rdy fell is kept and consumed on the first cycle after the freeze.
  assign byte_in    = frz_q ? din_hold_q : mem_din;
  assign io_stall   = io_buffer_full && (mem_a_q >= IO_BASE);
  assign pulse_busy = ld_ok_q || st_ok_q || if_ok_q;
  assign iss_nx     = iss_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    len_d     = len_q;
    sgn_d     = sgn_q;
    iss_d     = iss_q;
    rcv_d     = rcv_q;
    avld_d    = avld_q;
    rpend_d   = rpend_q;
    buf_d     = buf_q;
    mem_a_d   = mem_a_q;
    dout_d    = dout_q;
    wr_d      = wr_q;
    ld_data_d = ld_data_q;
    instr_d   = instr_q;
    ld_ok_d   = 1'b0;
    st_ok_d   = 1'b0;
    if_ok_d   = 1'b0;
    assembled = buf_q;
    assembled[{rcv_q[1:0], 3'b000} +: 8] = byte_in;

    case (state_q)
      S_IDLE: begin
        if (!pulse_busy && !jump_wrong) begin
          if (lsb_write_signal) begin
            state_d = S_STORE;
            addr_d  = to_mem_addr;
            len_d   = requiring_length;
            wdata_d = to_mem_data;
            mem_a_d = to_mem_addr;
            dout_d  = to_mem_data[7:0];
            wr_d    = 1'b1;
            iss_d   = 3'd0;
          end else if (lsb_read_signal || if_request) begin
            state_d = lsb_read_signal ? S_LOAD : S_FETCH;
            addr_d  = lsb_read_signal ? to_mem_addr : if_addr;
            len_d   = lsb_read_signal ? requiring_length : 3'd4;
            sgn_d   = lsb_read_signal && load_signed;
            mem_a_d = lsb_read_signal ? to_mem_addr : if_addr;
            iss_d   = 3'd1;
            rcv_d   = 3'd0;
            avld_d  = 1'b1;
            rpend_d = 1'b0;
            buf_d   = '0;
            wr_d    = 1'b0;
            dout_d  = 8'h00;
          end
        end
      end

      S_FETCH, S_LOAD: begin
        if (jump_wrong) begin
          state_d = S_IDLE;
          iss_d   = 3'd0;
          rcv_d   = 3'd0;
          avld_d  = 1'b0;
          rpend_d = 1'b0;
          wr_d    = 1'b0;
        end else begin
          // rpend marks that mem_din now carries the byte addressed last cycle
          rpend_d = avld_q;
          avld_d  = (iss_q < len_q);
          if (iss_q < len_q) begin
            mem_a_d = addr_q + {29'b0, iss_q};
            iss_d   = iss_nx;
          end
          if (rpend_q) begin
            buf_d = assembled;
            rcv_d = rcv_q + 3'd1;
            if (rcv_q == len_q - 3'd1) begin
              state_d = S_IDLE;
              iss_d   = 3'd0;
              rcv_d   = 3'd0;
              avld_d  = 1'b0;
              rpend_d = 1'b0;
              if (state_q == S_FETCH) begin
                if_ok_d = 1'b1;
                instr_d = assembled;
              end else begin
                ld_ok_d   = 1'b1;
                ld_data_d = extend(assembled, len_q, sgn_q);
              end
            end
          end
        end
      end

      S_STORE: begin
        if (!io_stall) begin
          if (iss_nx < len_q) begin
            iss_d   = iss_nx;
            mem_a_d = addr_q + {29'b0, iss_nx};
            dout_d  = wdata_q[{iss_nx[1:0], 3'b000} +: 8];
          end else begin
            state_d = S_IDLE;
            iss_d   = 3'd0;
            wr_d    = 1'b0;
            dout_d  = 8'h00;
            st_ok_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      len_q     <= '0;
      sgn_q     <= 1'b0;
      iss_q     <= '0;
      rcv_q     <= '0;
      avld_q    <= 1'b0;
      rpend_q   <= 1'b0;
      buf_q     <= '0;
      mem_a_q   <= '0;
      dout_q    <= '0;
      wr_q      <= 1'b0;
      ld_data_q <= '0;
      instr_q   <= '0;
      ld_ok_q   <= 1'b0;
      st_ok_q   <= 1'b0;
      if_ok_q   <= 1'b0;
    end else if (rdy) begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      len_q     <= len_d;
      sgn_q     <= sgn_d;
      iss_q     <= iss_d;
      rcv_q     <= rcv_d;
      avld_q    <= avld_d;
      rpend_q   <= rpend_d;
      buf_q     <= buf_d;
      mem_a_q   <= mem_a_d;
      dout_q    <= dout_d;
      wr_q      <= wr_d;
      ld_data_q <= ld_data_d;
      instr_q   <= instr_d;
      ld_ok_q   <= ld_ok_d;
      st_ok_q   <= st_ok_d;
      if_ok_q   <= if_ok_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frz_q      <= 1'b0;
      din_hold_q <= '0;
    end else begin
      frz_q <= !rdy;
      if (!frz_q) din_hold_q <= mem_din;
    end
  end

  assign mem_a             = mem_a_q;
  assign mem_dout          = dout_q;
  assign mem_wr            = wr_q && rdy && !io_stall;
  assign from_mem_data     = ld_data_q;
  assign if_instr          = instr_q;
  assign mem_load_success  = ld_ok_q;
  assign mem_store_success = st_ok_q;
  assign if_success        = if_ok_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed table-driven bench for mem_ctrl with a behavioural byte RAM
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, jump_wrong;
  logic        lsb_read_signal, lsb_write_signal;
  logic [2:0]  requiring_length;
  logic [31:0] to_mem_addr, to_mem_data;
  logic        load_signed;
  logic        mem_load_success, mem_store_success, if_success;
  logic [31:0] from_mem_data, if_instr;
  logic        if_request;
  logic [31:0] if_addr;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
    .lsb_read_signal(lsb_read_signal), .lsb_write_signal(lsb_write_signal),
    .requiring_length(requiring_length), .to_mem_addr(to_mem_addr),
    .to_mem_data(to_mem_data), .load_signed(load_signed),
    .mem_load_success(mem_load_success), .from_mem_data(from_mem_data),
    .mem_store_success(mem_store_success), .if_request(if_request),
    .if_addr(if_addr), .if_success(if_success), .if_instr(if_instr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    mem_din <= ram[mem_a[11:0]];
  end

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t wlog[$];
  int  cur_c = 0;
  int  if_pulses = 0;

  always @(negedge clk) begin
    if (mem_wr) wlog.push_back('{cur_c, mem_a, mem_dout});
    if (if_success) if_pulses++;
  end

  typedef struct {
    logic        f;
    logic [31:0] a;
    logic [2:0]  n;
    logic        s;
    logic [31:0] exp;
  } rvec_t;
  rvec_t tbl [9];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic do_read(input string nm, input logic f, input logic [31:0] a,
                         input logic [2:0] n, input logic s, input int frz_at,
                         input int jw_c, input int maxc,
                         output logic [31:0] d, output int lat);
    int c;
    if (f) begin
      if_request = 1'b1; if_addr = a;
    end else begin
      lsb_read_signal = 1'b1; to_mem_addr = a; requiring_length = n; load_signed = s;
    end
    c = 0; lat = -1; d = '0;
    while (lat < 0 && c < maxc) begin
      cur_c = c;
      rdy = !(frz_at > 0 && c >= frz_at && c < frz_at + 3);
      jump_wrong = (c == jw_c);
      if (c == jw_c) begin
        if (f) if_request = 1'b0; else lsb_read_signal = 1'b0;
      end
      @(negedge clk);
      if (frz_at == 0 && c >= 1 && c <= int'(n)) begin
        chk($sformatf("%s mem_a c%0d", nm, c), mem_a, a + 32'(c - 1));
        chk($sformatf("%s rd wr/dout c%0d", nm, c), {23'b0, mem_wr, mem_dout}, 32'h0);
      end
      if (f ? if_success : mem_load_success) begin
        lat = c;
        d = f ? if_instr : from_mem_data;
      end
      @(posedge clk); #1;
      c++;
    end
    if (f) if_request = 1'b0; else lsb_read_signal = 1'b0;
    rdy = 1'b1; jump_wrong = 1'b0;
  endtask

  task automatic do_store(input string nm, input logic [31:0] a, input logic [2:0] n,
                          input logic [31:0] d, input int st_lo, input int st_hi,
                          input int jw_c, input int rst_c, input int maxc,
                          output int lat);
    int c;
    wlog.delete();
    lsb_write_signal = 1'b1; to_mem_addr = a; requiring_length = n; to_mem_data = d;
    c = 0; lat = -1;
    while (lat < 0 && c < maxc) begin
      cur_c = c;
      io_buffer_full = (c >= st_lo && c <= st_hi);
      jump_wrong = (c == jw_c);
      rst = (c == rst_c);
      if (c == rst_c) lsb_write_signal = 1'b0;
      @(negedge clk);
      if (mem_store_success) lat = c;
      if (c == rst_c + 1) begin
        chk({nm, " rst mem_a"}, mem_a, 32'h0);
        chk({nm, " rst wr/dout"}, {23'b0, mem_wr, mem_dout}, 32'h0);
        chk({nm, " rst from_mem_data"}, from_mem_data, 32'h0);
        chk({nm, " rst if_instr"}, if_instr, 32'h0);
        chk({nm, " rst pulses"}, {29'b0, mem_load_success, mem_store_success, if_success}, 32'h0);
      end
      @(posedge clk); #1;
      c++;
    end
    lsb_write_signal = 1'b0; io_buffer_full = 1'b0; jump_wrong = 1'b0; rst = 1'b0;
  endtask

  logic [31:0] d, dv;
  int          lat, p0;

  initial begin
    tbl[0] = '{1'b0, 32'h0000_0100, 3'd4, 1'b0, 32'h1234_5678};
    tbl[1] = '{1'b0, 32'h0000_0200, 3'd1, 1'b1, 32'hFFFF_FF80};
    tbl[2] = '{1'b0, 32'h0000_0200, 3'd1, 1'b0, 32'h0000_0080};
    tbl[3] = '{1'b0, 32'h0000_0200, 3'd2, 1'b1, 32'hFFFF_FF80};
    tbl[4] = '{1'b0, 32'h0000_0200, 3'd2, 1'b0, 32'h0000_FF80};
    tbl[5] = '{1'b0, 32'h0000_0201, 3'd1, 1'b1, 32'hFFFF_FFFF};
    tbl[6] = '{1'b0, 32'hFFFF_FFFF, 3'd2, 1'b0, 32'h0000_1234};
    tbl[7] = '{1'b1, 32'h0000_0040, 3'd4, 1'b0, 32'h0010_0093};
    tbl[8] = '{1'b0, 32'h0000_0202, 3'd2, 1'b1, 32'h0000_7FFE};

    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
    ram[12'h200] = 8'h80; ram[12'h201] = 8'hFF; ram[12'h202] = 8'hFE; ram[12'h203] = 8'h7F;
    ram[12'hFFF] = 8'h34; ram[12'h000] = 8'h12;
    ram[12'h040] = 8'h93; ram[12'h041] = 8'h00; ram[12'h042] = 8'h10; ram[12'h043] = 8'h00;

    rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0;
    lsb_read_signal = 1'b0; lsb_write_signal = 1'b0; requiring_length = 3'd1;
    to_mem_addr = '0; to_mem_data = '0; load_signed = 1'b0;
    if_request = 1'b0; if_addr = '0; io_buffer_full = 1'b0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset mem_a", mem_a, 32'h0);
    chk("reset wr/dout", {23'b0, mem_wr, mem_dout}, 32'h0);
    chk("reset from_mem_data", from_mem_data, 32'h0);
    chk("reset if_instr", if_instr, 32'h0);
    chk("reset pulses", {29'b0, mem_load_success, mem_store_success, if_success}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_read($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].n, tbl[i].s, 0, 99, 20, d, lat);
      chk($sformatf("vec%0d data", i), d, tbl[i].exp);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(int'(tbl[i].n) + 2));
    end

    do_read("freeze", 1'b0, 32'h100, 3'd4, 1'b0, 3, 99, 30, d, lat);
    chk("freeze data", d, 32'h1234_5678);
    chk("freeze latency", 32'(lat), 32'd9);

    do_store("iostall", 32'h0003_0004, 3'd2, 32'hAABB_CCDD, 1, 2, 99, 99, 15, lat);
    chk("iostall latency", 32'(lat), 32'd5);
    chk("iostall nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("iostall w0", {wlog[0].a[23:0], wlog[0].d}, {24'h03_0004, 8'hDD});
      chk("iostall w0 cycle", 32'(wlog[0].c), 32'd3);
      chk("iostall w1", {wlog[1].a[23:0], wlog[1].d}, {24'h03_0005, 8'hCC});
      chk("iostall w1 cycle", 32'(wlog[1].c), 32'd4);
    end

    dv = 32'h1122_3344;
    do_store("jwstore", 32'h300, 3'd4, dv, 99, -1, 2, 99, 15, lat);
    chk("jwstore latency", 32'(lat), 32'd5);
    chk("jwstore nwrites", 32'(wlog.size()), 32'd4);
    for (int k = 0; k < 4 && k < wlog.size(); k++) begin
      chk($sformatf("jwstore w%0d", k), {wlog[k].a[23:0], wlog[k].d},
          {24'h300 + 24'(k), dv[8*k +: 8]});
      chk($sformatf("jwstore w%0d cycle", k), 32'(wlog[k].c), 32'(k + 1));
    end
    do_read("readback", 1'b0, 32'h300, 3'd4, 1'b0, 0, 99, 20, d, lat);
    chk("readback data", d, 32'h1122_3344);

    p0 = if_pulses;
    do_read("flushfetch", 1'b1, 32'h40, 3'd4, 1'b0, 0, 3, 4, d, lat);
    chk("flush no pulse lat", 32'(lat), 32'hFFFF_FFFF);
    do_read("afterflush", 1'b0, 32'h100, 3'd1, 1'b0, 0, 99, 20, d, lat);
    chk("afterflush data", d, 32'h0000_0078);
    chk("afterflush latency", 32'(lat), 32'd3);
    chk("flush if_success count", 32'(if_pulses - p0), 32'd0);

    if_request = 1'b1; if_addr = 32'h40;
    p0 = if_pulses;
    do_read("arb_load", 1'b0, 32'h200, 3'd1, 1'b0, 0, 99, 20, d, lat);
    chk("arb load data", d, 32'h0000_0080);
    chk("arb load latency", 32'(lat), 32'd3);
    chk("arb no early fetch", 32'(if_pulses - p0), 32'd0);
    do_read("arb_fetch", 1'b1, 32'h40, 3'd4, 1'b0, 0, 99, 20, d, lat);
    chk("arb fetch data", d, 32'h0010_0093);
    chk("arb fetch latency", 32'(lat), 32'd6);

    do_store("rststore", 32'h310, 3'd4, 32'hDEAD_BEEF, 99, -1, 99, 2, 10, lat);
    chk("rststore no pulse", 32'(lat), 32'hFFFF_FFFF);
    do_read("postrst", 1'b0, 32'h100, 3'd4, 1'b0, 0, 99, 20, d, lat);
    chk("postrst data", d, 32'h1234_5678);
    chk("postrst latency", 32'(lat), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
